bin_to_bcd_converter: RTL and testbench

//  Sequential double-dabble converter: turns the calculator's unsigned binary result into packed BCD.

---
 rtl/bin_to_bcd_converter_pkg.sv | 14 +
 rtl/bin_to_bcd_converter_bcd_add3.sv | 7 +
 rtl/bin_to_bcd_converter.sv | 86 ++++++++
 tb/tb_bin_to_bcd_converter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_converter_pkg.sv
// bin_to_bcd_converter_pkg: shared widths, limits and FSM encoding for the BCD converter
package bin_to_bcd_converter_pkg;
  localparam int DISP_DIGITS = 4;
  localparam int CALC_BIN_W = 14;
  localparam int CALC_MAX_VAL = 9999;
  localparam logic [15:0] BCD_NINES = 16'h9999;
  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
endpackage

// File: rtl/bin_to_bcd_converter_bcd_add3.sv
// bcd_add3: double-dabble digit cell, adds 3 to a nibble that is 5 or more
module bcd_add3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);
  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/bin_to_bcd_converter.sv
// bin_to_bcd_converter: sequential double-dabble binary to packed BCD with saturation on overflow
module bin_to_bcd_converter
  import bin_to_bcd_converter_pkg::*;
#(
  parameter int BIN_W = CALC_BIN_W,
  parameter int DIGITS = DISP_DIGITS
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd_out
);
  localparam int SW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] MAX_B = BIN_W'(pow10(DIGITS) - 1);
  localparam logic [SW-1:0] NINES = {DIGITS{4'h9}};
  state_t state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [SW-1:0] scr_q, scr_d, adj, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_pend_q, ovf_pend_d, ovf_q, ovf_d, done_q, done_d;
  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (.d_i(scr_q[4*g +: 4]), .d_o(adj[4*g +: 4]));
    end
  endgenerate
  // state and datapath registers, all cleared by clr
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      bin_q <= '0;
      scr_q <= '0;
      cnt_q <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q <= 1'b0;
      bcd_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q <= bin_d;
      scr_q <= scr_d;
      cnt_q <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q <= ovf_d;
      bcd_q <= bcd_d;
      done_q <= done_d;
    end
  end
  // capture in IDLE, adjust-and-shift in SHIFT, publish the result on the last shift
  always_comb begin
    state_d = state_q;
    bin_d = bin_q;
    scr_d = scr_q;
    cnt_d = cnt_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d = ovf_q;
    bcd_d = bcd_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE && start) begin
      state_d = ST_SHIFT;
      bin_d = bin_in;
      scr_d = '0;
      cnt_d = CW'(BIN_W);
      ovf_pend_d = bin_in > MAX_B;
    end else if (state_q == ST_SHIFT) begin
      scr_d = {adj[SW-2:0], bin_q[BIN_W-1]};
      bin_d = {bin_q[BIN_W-2:0], 1'b0};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        state_d = ST_IDLE;
        bcd_d = ovf_pend_q ? NINES : {adj[SW-2:0], bin_q[BIN_W-1]};
        ovf_d = ovf_pend_q;
        done_d = 1'b1;
      end
    end
  end
  assign busy = (state_q == ST_SHIFT);
  assign done = done_q;
  assign overflow = ovf_q;
  assign bcd_out = bcd_q;
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb_bin_to_bcd_converter: directed table and corner-sequence checks for the BCD converter
module tb_bin_to_bcd_converter;
  logic clk = 1'b0;
  logic clr, start, busy, done, overflow;
  logic [13:0] bin_in;
  logic [15:0] bcd_out;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic ovf;
  } vec_t;
  vec_t vecs[12];
  int n, bn, dn;

  bin_to_bcd_converter dut (
    .clk(clk), .clr(clr), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .overflow(overflow), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic do_conv(input logic [13:0] v, output int lat, output int busy_n);
    @(negedge clk);
    bin_in = v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_n = 0;
    while (!done && lat < 60) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[1]  = '{14'd0,     16'h0000, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[5]  = '{14'd42,    16'h0042, 1'b0};
    vecs[6]  = '{14'd1,     16'h0001, 1'b0};
    vecs[7]  = '{14'd10,    16'h0010, 1'b0};
    vecs[8]  = '{14'd5,     16'h0005, 1'b0};
    vecs[9]  = '{14'd8191,  16'h8191, 1'b0};
    vecs[10] = '{14'd9000,  16'h9000, 1'b0};
    vecs[11] = '{14'd555,   16'h0555, 1'b0};
    clr = 1'b1;
    start = 1'b0;
    bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_bcd", 32'(bcd_out), 0);
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_conv(vecs[i].bin, n, bn);
      chk($sformatf("lat_%0d", i), 32'(n), 15);
      chk($sformatf("busy_cycles_%0d", i), 32'(bn), 14);
      chk($sformatf("busy_at_done_%0d", i), 32'(busy), 0);
      chk($sformatf("bcd_%0d", i), 32'(bcd_out), 32'(vecs[i].bcd));
      chk($sformatf("ovf_%0d", i), 32'(overflow), 32'(vecs[i].ovf));
      @(negedge clk);
      chk($sformatf("done_width_%0d", i), 32'(done), 0);
      chk($sformatf("bcd_hold_%0d", i), 32'(bcd_out), 32'(vecs[i].bcd));
    end
    for (int v = 0; v <= 9999; v += 7) begin
      do_conv(14'(v), n, bn);
      chk($sformatf("sweep_%0d", v), 32'(bcd_out), 32'(ref_bcd(v)));
    end
    // start while busy and bin_in toggling are ignored
    @(negedge clk);
    bin_in = 14'd1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    bin_in = 14'd77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bin_in = 14'd5555;
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        dn++;
        chk("t4_bcd", 32'(bcd_out), 32'h1234);
      end
      @(negedge clk);
    end
    chk("t4_done_count", 32'(dn), 1);
    // start held high: back-to-back conversions every 15 cycles
    @(negedge clk);
    bin_in = 14'd7;
    start = 1'b1;
    wait_done(n);
    chk("t5_first_lat", 32'(n), 15);
    chk("t5_bcd7", 32'(bcd_out), 32'h0007);
    bin_in = 14'd8;
    @(negedge clk);
    chk("t5_busy_after_done", 32'(busy), 1);
    wait_done(n);
    chk("t5_period", 32'(n + 1), 15);
    chk("t5_bcd8", 32'(bcd_out), 32'h0008);
    start = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(busy), 0);
    // clr aborts a conversion in flight
    do_conv(14'd555, n, bn);
    chk("t6_prev", 32'(bcd_out), 32'h0555);
    @(negedge clk);
    bin_in = 14'd4321;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_bcd", 32'(bcd_out), 0);
    chk("t6_ovf", 32'(overflow), 0);
    chk("t6_done", 32'(done), 0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("t6_no_done", 32'(dn), 0);
    clr = 1'b1;
    start = 1'b1;
    bin_in = 14'd99;
    @(negedge clk);
    clr = 1'b0;
    start = 1'b0;
    chk("t6_clr_wins", 32'(busy), 0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("t6_clr_wins_no_done", 32'(dn), 0);
    chk("t6_clr_wins_bcd", 32'(bcd_out), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
